ahb_slv_sram: RTL and testbench
===============================

AHB_SLV_SRAM -- requirements
Module: ahb_slv_sram

Interface
REQ-001 SHALL have parameter DW, default 32, data bus width in bits.
REQ-002 SHALL have parameter AW, default 32, address bus width in bits.
REQ-003 SHALL have parameter MEM_DEPTH, default 256, number of DW-bit words of storage.
REQ-004 SHALL have parameter WAIT_CYCLES, default 2, wait states per transfer when AHB_SLV_WAIT_EN is defined (legal range 1..15).
REQ-005 SHALL have port hclk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port hresetn, input, 1 bit: reset, synchronous, active-low.
REQ-007 SHALL have port hsel, input, 1 bit: slave select.
REQ-008 SHALL have port haddr, input, AW bits: byte address.
REQ-009 SHALL have port htrans, input, 2 bits: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-010 SHALL have ports hwrite (input, 1 bit), hsize (input, 3 bits), hburst (input, 3 bits) and hprot (input, 4 bits); hburst and hprot are accepted and ignored.
REQ-011 SHALL have port hwdata, input, DW bits: write data, sampled in the data phase.
REQ-012 SHALL have port hready, input, 1 bit: bus-level ready, qualifies address-phase capture.
REQ-013 SHALL have ports hreadyout (output, 1 bit), hresp (output, 1 bit, 0=OKAY, 1=ERROR) and hrdata (output, DW bits, registered).

Function
REQ-014 SHALL capture a transfer (address, hwrite, hsize) only when hsel=1, hready=1 and htrans[1]=1 at a rising edge.
REQ-015 SHALL answer IDLE, BUSY, or unselected cycles with hreadyout=1 and hresp=0 in the following cycle, with no memory access.
REQ-016 SHALL implement FSM states IDLE, WAIT, DATA, ERR1 and ERR2.
REQ-017 SHALL transition IDLE/DATA/ERR2 -> DATA on a valid capture, or -> WAIT on a valid capture when wait states are enabled; WAIT -> DATA after WAIT_CYCLES cycles with hreadyout=0.
REQ-018 SHALL treat a transfer as an error when the word index haddr[AW-1:2] >= MEM_DEPTH, hsize > 2, or the address is misaligned for hsize.
REQ-019 SHALL respond to an error with a two-cycle ERROR: ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1); errored writes SHALL NOT modify memory.
REQ-020 SHALL drive hreadyout=1 and hresp=0 in DATA, completing the transfer.
REQ-021 SHALL write hwdata byte lanes selected by hsize and haddr[1:0] (little-endian) at the rising edge ending DATA of a write.
REQ-022 SHALL present read data on hrdata during the cycle in which hreadyout=1 in DATA; with zero wait, latency is exactly one cycle after the address phase.
REQ-023 SHALL forward the byte lanes of a write being completed to a read captured at the same edge to the same word (read-after-write).
REQ-024 SHALL hold hrdata at its last value outside read data phases.
REQ-025 SHALL accept back-to-back pipelined transfers (an address phase overlapping the previous data phase) without bubbles in zero-wait mode.

Reset
REQ-026 SHALL, when hresetn=0 at a rising edge, enter IDLE with hreadyout=1, hresp=0 and hrdata=0, and discard any in-flight transfer (a pending write is not committed).
REQ-027 SHALL NOT clear memory contents on reset.

Configuration
REQ-028 SHALL, with macro AHB_SLV_WAIT_EN defined, insert WAIT_CYCLES cycles of hreadyout=0, hresp=0 before DATA for every valid non-error transfer.
REQ-029 SHALL, without AHB_SLV_WAIT_EN, never enter WAIT; all OKAY transfers are zero-wait. Error timing is identical in both builds.

Verification
REQ-030 Zero-wait single write then read: write 0xDEADBEEF to 0x10, then read 0x10 -> hreadyout=1 in every cycle; hrdata=0xDEADBEEF one cycle after the read address phase.
REQ-031 Pipelined INCR8: eight writes to 0x00..0x1C with data 0..7, followed by an INCR8 read -> eight consecutive OKAY beats returning 0..7 with no stalls.
REQ-032 Read-after-write: write 0x12345678 to 0x20 with the read of 0x20 issued in the next address phase -> hrdata=0x12345678.
REQ-033 Error: read 0x400 with MEM_DEPTH=256, and a word write to 0x02 -> ERR1/ERR2 pattern (hreadyout 0 then 1, hresp=1 both cycles); memory unchanged.
REQ-034 AHB_SLV_WAIT_EN with WAIT_CYCLES=2: single read -> hreadyout low for 2 cycles, then high with data and hresp=0.
REQ-035 Reset mid-transfer: assert hresetn=0 during WAIT of a write of 0xAAAA5555 to 0x30 -> next cycle hreadyout=1, hresp=0, hrdata=0; a later read of 0x30 returns the old contents.

Source files
------------

// File: rtl/ahb_slv_sram.sv
`default_nettype none
// +------------------------------------------------------------------------------+
// | Module  : ahb_slv_sram                                                       |
// | Desc    : AHB-Lite SRAM slave; zero-wait, or WAIT_CYCLES wait states when    |
// |           the AHB_SLV_WAIT_EN macro is defined.                              |
// | Rev     : 1.0                                                                |
// +------------------------------------------------------------------------------+
module ahb_slv_sram #(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          hclk,
  input  logic          hresetn,
  input  logic          hsel,
  input  logic [AW-1:0] haddr,
  input  logic [1:0]    htrans,
  input  logic          hwrite,
  input  logic [2:0]    hsize,
  input  logic [2:0]    hburst,
  input  logic [3:0]    hprot,
  input  logic [DW-1:0] hwdata,
  input  logic          hready,
  output logic          hreadyout,
  output logic          hresp,
  output logic [DW-1:0] hrdata
);

  localparam int            c_nb    = DW / 8;
  localparam int            c_iw    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [AW-1:0] c_depth = AW'(MEM_DEPTH);
`ifdef AHB_SLV_WAIT_EN
  localparam bit c_wait_en = 1'b1;
`else
  localparam bit c_wait_en = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q;
  logic [c_iw-1:0]   addr_q;
  logic [c_nb-1:0]   be_q;
  logic [DW-1:0]     hrdata_q;

  logic              w_accept, w_cap, w_err, w_misal, w_oor;
  logic              w_commit, w_rd_load;
  logic [c_nb-1:0]   w_be;
  logic [c_iw-1:0]   w_idx, w_rd_idx;
  logic [DW-1:0]     w_rd_data;
  logic              w_unused;

  assign w_unused = ^{hburst, hprot};

  assign w_accept = (state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2);
  assign w_cap    = hsel & hready & htrans[1] & w_accept;
  assign w_idx    = haddr[c_iw+1:2];
  assign w_oor    = {2'b00, haddr[AW-1:2]} >= c_depth;
  assign w_misal  = ((hsize == 3'd1) && haddr[0]) || ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
  assign w_err    = w_oor | (hsize > 3'd2) | w_misal;

  always_comb begin
    w_be = '0;
    case (hsize)
      3'd0:    w_be[haddr[1:0]] = 1'b1;
      3'd1:    w_be[{haddr[1], 1'b0} +: 2] = 2'b11;
      default: w_be = '1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    case (state_q)
      S_WAIT: begin
        hreadyout = 1'b0;
        if (cnt_q == '0) state_d = S_DATA;
        else             cnt_d   = cnt_q - 4'd1;
      end
      S_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_d   = S_ERR2;
      end
      default: begin
        if (state_q == S_ERR2) hresp = 1'b1;
        if (!w_cap)         state_d = S_IDLE;
        else if (w_err)     state_d = S_ERR1;
        else if (c_wait_en) begin
          state_d = S_WAIT;
          cnt_d   = 4'(WAIT_CYCLES - 1);
        end
        else                state_d = S_DATA;
      end
    endcase
  end

  // A write retires on the edge that ends DATA; reset at that edge drops it.
  assign w_commit  = hresetn && (state_q == S_DATA) && wr_q;
  assign w_rd_idx  = (state_q == S_WAIT) ? addr_q : w_idx;
  assign w_rd_load = c_wait_en ? ((state_q == S_WAIT) && (cnt_q == '0) && !wr_q)
                               : (w_cap && !w_err && !hwrite);

  for (genvar b = 0; b < c_nb; b++) begin : g_lane
    logic [7:0] mem_q [MEM_DEPTH];

    always_ff @(posedge hclk) begin
      if (w_commit && be_q[b]) mem_q[addr_q] <= hwdata[8*b +: 8];
    end

    assign w_rd_data[8*b +: 8] = (w_commit && be_q[b] && (addr_q == w_rd_idx))
                               ? hwdata[8*b +: 8] : mem_q[w_rd_idx];
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      hrdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (w_cap) begin
        addr_q <= w_idx;
        be_q   <= w_be;
        wr_q   <= hwrite & ~w_err;
      end
      if (w_rd_load) hrdata_q <= w_rd_data;
    end
  end

  assign hrdata = hrdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_slv_sram.sv
`default_nettype none
// +------------------------------------------------------------------------------+
// | Module  : tb_ahb_slv_sram                                                    |
// | Desc    : Randomized pipelined-master bench for ahb_slv_sram with a          |
// |           byte-array reference memory.                                      |
// | Rev     : 1.0                                                                |
// +------------------------------------------------------------------------------+
module tb_ahb_slv_sram;

  localparam int DEPTH = 256;
`ifdef AHB_SLV_WAIT_EN
  localparam int WS = 2;
`else
  localparam int WS = 0;
`endif

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;

  assign hready = hreadyout;

  ahb_slv_sram #(.DW(32), .AW(32), .MEM_DEPTH(DEPTH), .WAIT_CYCLES(2)) u_dut (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
    .hready(hready), .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata)
  );

  always #5 hclk = ~hclk;

  // kind: 0 transfer, 1 IDLE, 2 BUSY, 3 unselected NONSEQ
  typedef struct {
    int unsigned kind;
    logic [1:0]  trans;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
  } xfer_t;

  xfer_t       q[$];
  logic [7:0]  mdl [DEPTH*4];
  logic [31:0] last_rd;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, act, exp);
    end
  endtask

  function automatic bit is_err(input xfer_t x);
    return (x.addr / 4 >= DEPTH) || (x.size > 2) || (x.addr % (1 << x.size) != 0);
  endfunction

  function automatic logic [31:0] mdl_rd(input logic [31:0] addr);
    int unsigned a;
    a = addr - (addr % 4);
    return {mdl[a+3], mdl[a+2], mdl[a+1], mdl[a]};
  endfunction

  function automatic void mdl_wr(input xfer_t x);
    int unsigned a;
    for (int i = 0; i < (1 << x.size); i++) begin
      a = x.addr + i;
      mdl[a] = x.data[8*(a%4) +: 8];
    end
  endfunction

  function automatic xfer_t mk(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                               input logic [31:0] data, input logic [1:0] trans);
    xfer_t x;
    x.kind = 0; x.wr = wr; x.addr = addr; x.size = size; x.data = data; x.trans = trans;
    return x;
  endfunction

  function automatic xfer_t mk_gap(input int unsigned kind);
    xfer_t x;
    x = mk(1'b0, 32'h0, 3'd2, 32'h0, 2'd0);
    x.kind = kind;
    return x;
  endfunction

  function automatic xfer_t gen_rand(input logic [31:0] prev);
    xfer_t       x;
    int unsigned r  = $urandom_range(0, 99);
    int unsigned ra = $urandom_range(0, 99);
    logic [31:0] a;
    logic [2:0]  s;
    if (r < 8)  return mk_gap(1);
    if (r < 12) return mk_gap(2);
    if (r < 16) return mk_gap(3);
    s = ($urandom_range(0, 19) < 2) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
    if (ra < 5)       a = 32'h400 + $urandom_range(0, 1023);
    else if (ra < 7)  a = 32'h8000_0000 | $urandom_range(0, 1023);
    else if (ra < 40) a = {prev[31:2], 2'($urandom_range(0, 3))};
    else              a = $urandom_range(0, DEPTH*4 - 1);
    if (s <= 3'd2 && $urandom_range(0, 9) != 0) a = a - (a % (1 << s));
    x = mk(1'($urandom_range(0, 1)), a, s, $urandom, ($urandom_range(0, 1) != 0) ? 2'd3 : 2'd2);
    return x;
  endfunction

  task automatic drive_addr(input xfer_t x);
    hburst = 3'($urandom_range(0, 7));
    hprot  = 4'($urandom_range(0, 15));
    haddr  = x.addr;
    hwrite = x.wr;
    hsize  = x.size;
    case (x.kind)
      0:       begin hsel = 1'b1; htrans = x.trans; end
      1:       begin hsel = 1'b1; htrans = 2'd0; hwrite = 1'($urandom_range(0, 1)); end
      2:       begin hsel = 1'b1; htrans = 2'd1; hwrite = 1'($urandom_range(0, 1)); end
      default: begin hsel = 1'b0; htrans = 2'd2; hwrite = 1'($urandom_range(0, 1)); end
    endcase
  endtask

  // Pipelined master: drains q, checks every cycle against the reference model.
  task automatic run_q();
    int    ai = 0;
    bit    dv = 1'b0;
    xfer_t dp;
    int    k = 0;
    int    exp_st;
    bit    de;
    logic  ro, rs;
    logic [31:0] rd;
    while (ai < q.size() || dv) begin
      if (ai < q.size()) drive_addr(q[ai]);
      else               drive_addr(mk_gap(1));
      hwdata = (dv && dp.wr) ? dp.data : $urandom;
      @(negedge hclk);
      ro = hreadyout; rs = hresp; rd = hrdata;
      if (dv) begin
        de     = is_err(dp);
        exp_st = de ? 1 : WS;
        chk("dp_ready", 32'(ro), 32'(k == exp_st));
        chk("dp_resp", 32'(rs), 32'(de));
        if (ro && !de) begin
          if (dp.wr) mdl_wr(dp);
          else       last_rd = mdl_rd(dp.addr);
        end
      end else begin
        chk("idle_ready", 32'(ro), 32'd1);
        chk("idle_resp", 32'(rs), 32'd0);
      end
      chk("hrdata", rd, last_rd);
      @(posedge hclk); #1;
      if (ro) begin
        k  = 0;
        dv = (ai < q.size()) && (q[ai].kind == 0);
        if (ai < q.size()) begin
          dp = q[ai];
          ai++;
        end
      end else begin
        k++;
        if (k > 40) begin
          chk("stall_bound", 32'(k), 32'd40);
          dv = 1'b0;
          ai = q.size();
        end
      end
    end
    q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prev;
    hresetn = 1'b0;
    drive_addr(mk_gap(1));
    hwdata  = 32'h0;
    last_rd = 32'h0;
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    chk("rst_ready", 32'(hreadyout), 32'd1);
    chk("rst_resp", 32'(hresp), 32'd0);
    chk("rst_hrdata", hrdata, 32'h0);
    @(posedge hclk); #1;
    hresetn = 1'b1;

    for (int i = 0; i < DEPTH; i++) q.push_back(mk(1'b1, 32'(i*4), 3'd2, $urandom, 2'd2));
    run_q();

    q.push_back(mk(1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 2'd2));
    q.push_back(mk_gap(1));
    q.push_back(mk(1'b0, 32'h10, 3'd2, 32'h0, 2'd2));
    run_q();

    for (int i = 0; i < 8; i++) q.push_back(mk(1'b1, 32'(i*4), 3'd2, 32'(i), (i == 0) ? 2'd2 : 2'd3));
    for (int i = 0; i < 8; i++) q.push_back(mk(1'b0, 32'(i*4), 3'd2, 32'h0, (i == 0) ? 2'd2 : 2'd3));
    run_q();

    q.push_back(mk(1'b1, 32'h20, 3'd2, 32'h12345678, 2'd2));
    q.push_back(mk(1'b0, 32'h20, 3'd2, 32'h0, 2'd2));
    run_q();

    q.push_back(mk(1'b0, 32'h400, 3'd2, 32'h0, 2'd2));
    q.push_back(mk(1'b1, 32'h02, 3'd2, 32'hFFFF_FFFF, 2'd2));
    q.push_back(mk(1'b0, 32'h00, 3'd2, 32'h0, 2'd2));
    q.push_back(mk(1'b1, 32'h05, 3'd0, 32'hA5A5_A5A5, 2'd2));
    q.push_back(mk(1'b1, 32'h0A, 3'd1, 32'h1234_5678, 2'd2));
    q.push_back(mk(1'b0, 32'h04, 3'd2, 32'h0, 2'd2));
    q.push_back(mk(1'b0, 32'h08, 3'd2, 32'h0, 2'd2));
    run_q();

    prev = 32'h0;
    for (int i = 0; i < 400; i++) begin
      q.push_back(gen_rand(prev));
      if (q[q.size()-1].kind == 0) prev = q[q.size()-1].addr;
    end
    run_q();

    // Reset lands on the edge after the write's address phase; the write must not retire.
    drive_addr(mk(1'b1, 32'h30, 3'd2, 32'hAAAA5555, 2'd2));
    @(posedge hclk); #1;
    drive_addr(mk_gap(1));
    hwdata  = 32'hAAAA5555;
    hresetn = 1'b0;
    @(posedge hclk); #1;
    hresetn = 1'b1;
    last_rd = 32'h0;
    @(negedge hclk);
    chk("rstmid_ready", 32'(hreadyout), 32'd1);
    chk("rstmid_resp", 32'(hresp), 32'd0);
    chk("rstmid_hrdata", hrdata, 32'h0);
    @(posedge hclk); #1;
    q.push_back(mk(1'b0, 32'h30, 3'd2, 32'h0, 2'd2));
    run_q();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
